// File: rtl/bcd_updown_7sd_counter.sv
// bcd_updown_7sd_counter
//   N-digit BCD up/down counter stepped by debounced push-buttons, driving N
//   seven-segment digits. Contains its own 2-flop synchronisers and debounce.
//
//   Optional feature macro: AUTO_REPEAT_EN -- when defined, holding Up or Down
//   generates extra steps after REPEAT_DELAY cycles, then every REPEAT_PERIOD.
//
// Ports:
//   i_Clk          system clock
//   i_Rst_L        asynchronous active-low reset
//   i_Switch_Up    raw increment button, 1 = pressed
//   i_Switch_Down  raw decrement button, 1 = pressed
//   i_Switch_Clear raw clear button, 1 = pressed
//   o_Count_BCD    registered count, digit 0 in bits [3:0]
//   o_Segments     registered segment drive, digit k in [7k+6:7k], A..G
//   o_Wrap         single-cycle pulse on up-wrap or down-wrap
module bcd_updown_7sd_counter #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned MAX_COUNT      = 99,
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned ACTIVE_LOW_SEG = 1,
    parameter int unsigned REPEAT_DELAY   = 12500000,
    parameter int unsigned REPEAT_PERIOD  = 2500000
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    input  logic                      i_Switch_Up,
    input  logic                      i_Switch_Down,
    input  logic                      i_Switch_Clear,
    output logic [4*NUM_DIGITS-1:0]   o_Count_BCD,
    output logic [7*NUM_DIGITS-1:0]   o_Segments,
    output logic                      o_Wrap
);

    localparam int unsigned BW = 4 * NUM_DIGITS;
    localparam int unsigned SW = 7 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(DEBOUNCE_LIMIT);

    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] r;
        int unsigned   t;
        r = '0;
        t = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1111110;
            4'd1:    p = 7'b0110000;
            4'd2:    p = 7'b1101101;
            4'd3:    p = 7'b1111001;
            4'd4:    p = 7'b0110011;
            4'd5:    p = 7'b1011011;
            4'd6:    p = 7'b1011111;
            4'd7:    p = 7'b1110000;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1111011;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    function automatic logic [SW-1:0] seg_word(input logic [BW-1:0] bcd);
        logic [SW-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            s[7*i +: 7] = seg_pat(bcd[4*i +: 4]);
        end
        return (ACTIVE_LOW_SEG != 0) ? ~s : s;
    endfunction

    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [BW-1:0] MAX_BCD = to_bcd(MAX_COUNT);
    localparam logic [SW-1:0] SEG_RST = seg_word('0);

    // Switch index: 0 = up, 1 = down, 2 = clear.
    logic [2:0]    sw_raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    deb_q, deb_d, deb_dly_q;
    logic [2:0]    arm_q, arm_d;
    logic [1:0]    valid_q;
    logic [CW-1:0] db_cnt_q [3];
    logic [CW-1:0] db_cnt_d [3];
    logic [2:0]    press;
    logic          step_up, step_dn;

    logic [BW-1:0] count_q, count_d;
    logic [SW-1:0] seg_q;
    logic          wrap_q, wrap_d;

    assign sw_raw = {i_Switch_Clear, i_Switch_Down, i_Switch_Up};

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == CW'(DEBOUNCE_LIMIT - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        // A switch is armed only once it has been seen released after reset,
        // so a button held through reset never counts as a fresh press.
        arm_d = arm_q | ({3{valid_q[1]}} & ~sync2_q);
    end

    assign press = deb_q & ~deb_dly_q & arm_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(RMAX + 1);

    logic [TW-1:0] rpt_tmr_q, rpt_tmr_d;
    logic          rpt_first_q, rpt_first_d;
    logic          rpt_step;
    logic          hold_one;

    assign hold_one = (deb_q[0] ^ deb_q[1]) & ~deb_q[2];

    // Timer value k means k cycles since the press event (or last repeat);
    // zero means idle, so a hold without a press event never repeats.
    always_comb begin
        rpt_tmr_d   = rpt_tmr_q;
        rpt_first_d = rpt_first_q;
        rpt_step    = 1'b0;
        if (!hold_one) begin
            rpt_tmr_d   = '0;
            rpt_first_d = 1'b0;
        end else if (press[0] || press[1]) begin
            rpt_tmr_d   = TW'(1);
            rpt_first_d = 1'b0;
        end else if (rpt_tmr_q != '0) begin
            if (rpt_tmr_q == TW'(rpt_first_q ? REPEAT_PERIOD : REPEAT_DELAY)) begin
                rpt_step    = 1'b1;
                rpt_tmr_d   = TW'(1);
                rpt_first_d = 1'b1;
            end else begin
                rpt_tmr_d = rpt_tmr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rpt_tmr_q   <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_tmr_q   <= rpt_tmr_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    assign step_up = press[0] | (rpt_step & deb_q[0]);
    assign step_dn = press[1] | (rpt_step & deb_q[1]);
`else
    assign step_up = press[0];
    assign step_dn = press[1];
`endif

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (press[2]) begin
            count_d = '0;
        end else if (step_up && step_dn) begin
            count_d = count_q;
        end else if (step_up) begin
            if (count_q == MAX_BCD) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = bcd_inc(count_q);
            end
        end else if (step_dn) begin
            if (count_q == '0) begin
                count_d = MAX_BCD;
                wrap_d  = 1'b1;
            end else begin
                count_d = bcd_dec(count_q);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            arm_q     <= '0;
            valid_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
            count_q   <= '0;
            wrap_q    <= 1'b0;
            seg_q     <= SEG_RST;
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            arm_q     <= arm_d;
            valid_q   <= {valid_q[0], 1'b1};
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            seg_q     <= seg_word(count_q);
        end
    end

    assign o_Count_BCD = count_q;
    assign o_Segments  = seg_q;
    assign o_Wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_updown_7sd_counter.sv
// tb_bcd_updown_7sd_counter
//   Self-checking bench: directed boundary cases plus randomized button
//   transactions, compared against an integer model of the counter.
module tb_bcd_updown_7sd_counter;

    localparam int unsigned ND = 2;
    localparam int unsigned DL = 4;
`ifdef AUTO_REPEAT_EN
    localparam int MC = 12;
`else
    localparam int MC = 99;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw_up, sw_dn, sw_clr;
    logic [7:0]  bcd;
    logic [13:0] seg;
    logic        wrap;

    int n_vec = 0;
    int n_err = 0;
    int wrap_hi = 0;
    int model = 0;

    always #5 clk = ~clk;

    bcd_updown_7sd_counter #(
        .NUM_DIGITS     (ND),
        .MAX_COUNT      (MC),
        .DEBOUNCE_LIMIT (DL),
        .ACTIVE_LOW_SEG (1),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) u_dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Switch_Up    (sw_up),
        .i_Switch_Down  (sw_dn),
        .i_Switch_Clear (sw_clr),
        .o_Count_BCD    (bcd),
        .o_Segments     (seg),
        .o_Wrap         (wrap)
    );

    // Total number of cycles o_Wrap was high; a 2-cycle pulse counts twice.
    always @(negedge clk) begin
        if (wrap === 1'b1) wrap_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_bcd(input int v);
        return 32'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            default: return 7'b1111011;
        endcase
    endfunction

    function automatic logic [31:0] exp_seg(input int v);
        logic [13:0] s;
        s = {~pat((v / 10) % 10), ~pat(v % 10)};
        return 32'(s);
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_bcd"}, 32'(bcd), exp_bcd(model));
        check({tag, "_seg"}, 32'(seg), exp_seg(model));
    endtask

    // combo = {clear, down, up}, all raised and released together.
    task automatic apply(input string tag, input logic [2:0] combo, input int hold);
        int w0;
        int expw;
        w0   = wrap_hi;
        expw = 0;
        @(negedge clk);
        {sw_clr, sw_dn, sw_up} = combo;
        repeat (hold) @(negedge clk);
        {sw_clr, sw_dn, sw_up} = 3'b000;
        repeat (12) @(negedge clk);
        if (combo[2]) begin
            model = 0;
        end else if (combo[1] && combo[0]) begin
            model = model;
        end else if (combo[0]) begin
            if (model == MC) begin model = 0; expw = 1; end
            else model = model + 1;
        end else if (combo[1]) begin
            if (model == 0) begin model = MC; expw = 1; end
            else model = model - 1;
        end
        check_state(tag);
        check({tag, "_wrap"}, 32'(wrap_hi - w0), 32'(expw));
    endtask

    task automatic glitch(input logic [2:0] combo);
        int w0;
        w0 = wrap_hi;
        @(negedge clk);
        {sw_clr, sw_dn, sw_up} = combo;
        repeat ($urandom_range(1, DL - 1)) @(negedge clk);
        {sw_clr, sw_dn, sw_up} = 3'b000;
        repeat (10) @(negedge clk);
        check_state("glitch");
        check("glitch_wrap", 32'(wrap_hi - w0), 32'd0);
    endtask

    task automatic set_count(input int v);
        apply("set_clr", 3'b100, 8);
        for (int i = 0; i < v; i++) apply("set_up", 3'b001, 6);
    endtask

    initial begin
        int r;
        int v42;
        rst_n = 1'b0;
        sw_up = 1'b0; sw_dn = 1'b0; sw_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(bcd), 32'h00);
        check("rst_seg", 32'(seg), 32'(14'b0000001_0000001));
        check("rst_wrap", 32'(wrap), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_state("idle");
        check("idle_wrap", 32'(wrap), 32'd0);

        // Short pulses are filtered.
        for (int i = 0; i < 4; i++) glitch(3'b001);

        // Exact latency: raw edge sampled first at edge 1, count at edge 7.
        @(negedge clk);
        sw_up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 6) check("lat_before", 32'(bcd), 32'h00);
            if (k == 7) check("lat_count", 32'(bcd), 32'h01);
            if (k == 7) check("lat_seg_old", 32'(seg[6:0]), 32'(7'b0000001));
            if (k == 8) check("lat_seg_new", 32'(seg[6:0]), 32'(7'b1001111));
            if (k == 10) sw_up = 1'b0;
        end
        repeat (12) @(negedge clk);
        model = 1;
        check_state("lat_settle");

        // Ripple carry and borrow.
        set_count(9);
        apply("up_9_10", 3'b001, 8);
        apply("dn_10_9", 3'b010, 8);

        // Wraps in both directions.
        apply("clr", 3'b100, 8);
        apply("dn_wrap", 3'b010, 8);
        apply("up_wrap", 3'b001, 8);

        // Simultaneous presses.
        v42 = (MC > 42) ? 42 : 7;
        set_count(v42);
        apply("up_dn", 3'b011, 8);
        apply("clr_up", 3'b101, 8);

        // Randomized transactions and glitches.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 10);
            if (r <= 3)       apply("rnd_up", 3'b001, $urandom_range(5, 12));
            else if (r <= 6)  apply("rnd_dn", 3'b010, $urandom_range(5, 12));
            else if (r == 7)  apply("rnd_clr", 3'b100, $urandom_range(5, 12));
            else if (r == 8)  apply("rnd_ud", 3'b011, $urandom_range(5, 12));
            else if (r == 9)  apply("rnd_any", 3'($urandom_range(1, 7)), $urandom_range(5, 12));
            else              glitch(3'($urandom_range(1, 7)));
        end

        // Reset asserted while Up is held.
        set_count(5);
        @(negedge clk);
        sw_up = 1'b1;
        repeat (10) @(negedge clk);
        model = 6;
        check_state("hold_pre_rst");
        rst_n = 1'b0;
        #1;
        model = 0;
        check_state("hold_rst");
        check("hold_rst_wrap", 32'(wrap), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_state("hold_after_rst");
        sw_up = 1'b0;
        repeat (12) @(negedge clk);
        check_state("hold_released");
        apply("hold_repress", 3'b001, 8);

`ifdef AUTO_REPEAT_EN
        // Auto-repeat: press plus repeats at +20, +25, +30, +35, +40.
        begin
            int w0;
            set_count(10);
            w0 = wrap_hi;
            @(negedge clk);
            sw_up = 1'b1;
            for (int k = 1; k <= 60; k++) begin
                @(negedge clk);
                if (k == 7)  check("rpt_press", 32'(bcd), exp_bcd(11));
                if (k == 26) check("rpt_wait", 32'(bcd), exp_bcd(11));
                if (k == 27) check("rpt_first", 32'(bcd), exp_bcd(12));
                if (k == 32) check("rpt_wrap", 32'(bcd), exp_bcd(0));
                if (k == 42) sw_up = 1'b0;
            end
            model = 3;
            check_state("rpt_final");
            check("rpt_wrap_cnt", 32'(wrap_hi - w0), 32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
